// File: rtl/fft_frame_packetizer.sv
// Buffers a free-running real sample stream in a small FIFO and frames it into
// fixed N-beat Avalon-ST packets for the FFT sink, tracking dropped samples.
module fft_frame_packetizer #(
  parameter int unsigned DW         = 16,
  parameter int unsigned N          = 64,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_in_valid,
  input  logic [DW-1:0]   i_in_data,
  output logic            o_src_valid,
  input  logic            i_src_ready,
  output logic            o_src_sop,
  output logic            o_src_eop,
  output logic [1:0]      o_src_error,
  output logic [2*DW-1:0] o_src_data,
  output logic            o_overflow,
  input  logic            i_clr_overflow,
  output logic [15:0]     o_drop_count,
  output logic [15:0]     o_frame_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
  localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   w_count;
  logic [PW-1:0]   w_count_left;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [BW-1:0]   r_beat;
  logic [BW-1:0]   w_beat_nxt;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_eop_accept;
  logic            w_valid_nxt;
  logic            w_sop_nxt;
  logic            w_eop_nxt;

  // A pop frees a slot in the same cycle, so a write into a full FIFO that is
  // being drained is not a drop.
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == DEPTH_P);
  assign w_pop        = o_src_valid & i_src_ready;
  assign w_push       = i_in_valid & (~w_full | w_pop);
  assign w_drop       = i_in_valid & w_full & ~w_pop;
  assign w_count_left = w_count - PW'(w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_eop_accept = w_pop & (r_beat == LAST_BEAT);
  assign o_src_error  = 2'b00;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_in_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frames start only from IDLE and stop only after an accepted EOP beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable && (w_count != '0)) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_eop_accept && !i_enable) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output view excludes this cycle's write, giving one cycle of write-to-valid latency.
  always_comb begin
    w_beat_nxt  = '0;
    w_valid_nxt = 1'b0;
    if (r_state == S_STREAM) begin
      w_beat_nxt = r_beat + BW'(w_pop);
    end
    if (w_state_nxt == S_STREAM) begin
      w_valid_nxt = (w_count_left != '0);
    end
    w_sop_nxt = w_valid_nxt & (w_beat_nxt == '0);
    w_eop_nxt = w_valid_nxt & (w_beat_nxt == LAST_BEAT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat      <= '0;
      o_src_valid <= 1'b0;
      o_src_sop   <= 1'b0;
      o_src_eop   <= 1'b0;
      o_src_data  <= '0;
    end else begin
      r_beat      <= w_beat_nxt;
      o_src_valid <= w_valid_nxt;
      o_src_sop   <= w_sop_nxt;
      o_src_eop   <= w_eop_nxt;
      if (w_valid_nxt) begin
        o_src_data <= {{DW{1'b0}}, r_mem[w_rd_ptr_nxt[AW-1:0]]};
      end
    end
  end

  // Clear has priority over a same-cycle drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (i_clr_overflow) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (w_drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != 16'hFFFF) begin
        o_drop_count <= o_drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_count <= '0;
    end else if (w_eop_accept) begin
      o_frame_count <= o_frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fft_frame_packetizer.sv
// Scoreboard bench for fft_frame_packetizer: a queue models the FIFO contents,
// a monitor checks every presented beat, framing and the status counters.
module tb_fft_frame_packetizer;

  localparam int unsigned DW    = 16;
  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            src_valid;
  logic            src_ready;
  logic            src_sop;
  logic            src_eop;
  logic [1:0]      src_error;
  logic [2*DW-1:0] src_data;
  logic            overflow;
  logic            clr_overflow;
  logic [15:0]     drop_count;
  logic [15:0]     frame_count;

  int              n_vec = 0;
  int              n_fail = 0;
  logic [DW-1:0]   sbq[$];
  int              pos = 0;
  logic [15:0]     exp_frames = '0;
  logic [15:0]     exp_drop = '0;
  logic            exp_ovf = 1'b0;
  logic [15:0]     frames_ref;

  fft_frame_packetizer #(.DW(DW), .N(N), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_src_valid    (src_valid),
    .i_src_ready    (src_ready),
    .o_src_sop      (src_sop),
    .o_src_eop      (src_eop),
    .o_src_error    (src_error),
    .o_src_data     (src_data),
    .o_overflow     (overflow),
    .i_clr_overflow (clr_overflow),
    .o_drop_count   (drop_count),
    .o_frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference FIFO: accepts a sample if there is room once this cycle's pop is taken.
  always begin
    logic drop;
    @(negedge clk);
    #1;
    drop = 1'b0;
    if (!rst_n) begin
      sbq.delete();
      exp_drop = '0;
      exp_ovf  = 1'b0;
    end else begin
      if (in_valid) begin
        if (sbq.size() < int'(DEPTH)) sbq.push_back(in_data);
        else drop = 1'b1;
      end
      if (clr_overflow) begin
        exp_drop = '0;
        exp_ovf  = 1'b0;
      end else if (drop) begin
        exp_ovf = 1'b1;
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end
    end
  end

  // Monitor: every presented beat must be the oldest buffered sample at its frame slot.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_ctrl", {src_valid, src_sop, src_eop, src_error, overflow, drop_count, frame_count}, '0);
      check("reset_data", src_data, '0);
      pos        = 0;
      exp_frames = '0;
    end else begin
      check("src_error", src_error, '0);
      check("overflow", overflow, exp_ovf);
      check("drop_count", drop_count, exp_drop);
      check("frame_count", frame_count, exp_frames);
      if (src_valid) begin
        check("head_avail", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          check("src_data", src_data, {16'h0000, sbq[0]});
          check("src_sop", src_sop, pos == 0);
          check("src_eop", src_eop, pos == int'(N) - 1);
          if (src_ready) begin
            void'(sbq.pop_front());
            if (pos == int'(N) - 1) exp_frames = exp_frames + 16'd1;
            pos = (pos + 1) % int'(N);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    in_valid     = 1'b0;
    clr_overflow = 1'b0;
    enable       = 1'b1;
    src_ready    = 1'b1;
    while (sbq.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check(name, 64'(sbq.size()), 0);
    repeat (3) tick();
  endtask

  // Streams random samples until the monitor reaches frame slot p.
  task automatic feed_until_pos(input int p, input string name);
    int cyc = 0;
    in_valid = 1'b1;
    while (pos != p && cyc < 100) begin
      in_data = DW'($urandom);
      tick();
      cyc++;
    end
    check(name, 64'(pos), 64'(p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    src_ready    = 1'b0;
    clr_overflow = 1'b0;

    // Reset held with in_valid pulsing
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      in_data  = DW'(16'hA5A0 + i);
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) tick();
    check("post_reset_valid", src_valid, 0);

    // Single frame, samples 1..8, with write-to-valid latency
    enable    = 1'b1;
    src_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      tick();
      if (i == 1) check("latency_edge_t", src_valid, 0);
      if (i == 2) check("latency_edge_t1", src_valid, 1);
    end
    drain("single_drain");
    check("single_frames", frame_count, 16'd1);

    // Backpressure with ready pattern 1,0,0,1
    for (int c = 0; c < 16; c++) begin
      src_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid  = (c % 2 == 0);
      in_data   = DW'($urandom);
      tick();
    end
    drain("bp_drain");
    check("bp_frames", frame_count, 16'd2);
    check("bp_no_drops", drop_count, 16'd0);

    // Overflow: 6 samples into a 4-deep FIFO with ready low
    src_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0100 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 16'd2);
    in_valid     = 1'b1;
    in_data      = DW'(16'h0BAD);
    clr_overflow = 1'b1;
    tick();
    in_valid     = 1'b0;
    clr_overflow = 1'b0;
    tick();
    check("clr_drops", drop_count, 16'd0);
    check("clr_flag", overflow, 0);
    src_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0200 + i);
      tick();
    end
    drain("ovf_drain");
    check("ovf_frames", frame_count, 16'd3);

    // enable dropped at beat 3 while samples keep arriving
    feed_until_pos(3, "en_reach_beat3");
    enable     = 1'b0;
    frames_ref = exp_frames;
    feed_until_pos(0, "en_frame_done");
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_idle_valid", src_valid, 0);
    end
    check("en_frames", frame_count, frames_ref + 16'd1);
    check("en_frames_abs", frame_count, 16'd4);

    // Reset mid-frame at beat 5, then a fresh frame
    enable = 1'b1;
    feed_until_pos(5, "rst_reach_beat5");
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0300 + i);
      tick();
    end
    drain("rst_drain");
    check("rst_frames", frame_count, 16'd1);

    // Randomized traffic: bursts, stalls, enable toggles, occasional clears
    for (int i = 0; i < 600; i++) begin
      in_valid     = ($urandom % 2) == 0;
      in_data      = DW'($urandom);
      src_ready    = (i < 300) ? (($urandom % 4) != 0) : (($urandom % 10) < 3);
      enable       = ($urandom % 8) != 0;
      clr_overflow = ($urandom % 50) == 0;
      tick();
    end
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
